// File: rtl/pack_metadata_mc.sv
// Multi-channel metadata packer: serialises a latched metadata word, LSB first,
// into the unused high bits of each channel sample, one slot per accepted strobe.
module pack_metadata_mc #(
    parameter int data_width      = 16,
    parameter int data_width_used = 12,
    parameter int num_channels    = 2,
    parameter int meta_data_width = 465,
    parameter logic [data_width-data_width_used-1:0] fill_value = '0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 init,
    input  logic [num_channels*data_width-1:0]   data_in,
    input  logic                                 strobe_in,
    input  logic [meta_data_width-1:0]           meta_data,
    output logic [num_channels*data_width-1:0]   data_out,
    output logic                                 strobe_out,
    output logic                                 meta_busy,
    output logic                                 meta_done,
    output logic                                 restart_err
);

    localparam int P     = data_width - data_width_used;
    localparam int CP    = num_channels * P;
    localparam int S     = (meta_data_width + CP - 1) / CP;
    localparam int MW    = S * CP;
    localparam int CNT_W = $clog2(S + 1);
    localparam int OW    = num_channels * data_width;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(S - 1);

    typedef enum logic {IDLE, PACK} state_t;

    state_t                     state_q, state_d;
    logic [meta_data_width-1:0] meta_q, meta_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [OW-1:0]              data_out_q, data_out_d;
    logic                       strobe_q;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    logic             accept;
    logic             packing;
    logic             last_slot;
    logic [MW-1:0]    src_ext;
    logic [CNT_W-1:0] cnt_src;
    logic [OW-1:0]    packed_word;

    assign accept = enable & strobe_in;

    // A concurrent init takes effect before the strobe, so slot 0 comes straight from meta_data.
    assign src_ext   = MW'(init ? meta_data : meta_q);
    assign cnt_src   = init ? '0 : cnt_q;
    assign packing   = init | (state_q == PACK);
    assign last_slot = (cnt_src == LAST_SLOT);

    generate
        for (genvar gi = 0; gi < num_channels; gi++) begin : g_chan
            logic [P-1:0] hi_bits;
            logic         unused_hi;
            assign hi_bits   = packing ? src_ext[gi*P +: P] : fill_value;
            assign unused_hi = ^data_in[gi*data_width + data_width_used +: P];
            assign packed_word[gi*data_width +: data_width] =
                {hi_bits, data_in[gi*data_width +: data_width_used]};
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            meta_q     <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            meta_q     <= meta_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            strobe_q   <= accept;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        meta_d  = init ? meta_data : meta_q;
        cnt_d   = cnt_src;
        if (init) begin
            state_d = PACK;
        end
        if (accept && packing) begin
            // Shift out the slot just emitted; zeros enter from the top.
            meta_d = meta_data_width'(src_ext >> CP);
            if (last_slot) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = PACK;
                cnt_d   = cnt_src + 1'b1;
            end
        end
    end

    always_comb begin
        data_out_d = accept ? packed_word : data_out_q;
        done_d     = accept & packing & last_slot;
        err_d      = init & (state_q == PACK);
    end

    assign data_out    = data_out_q;
    assign strobe_out  = strobe_q;
    assign meta_busy   = (state_q == PACK);
    assign meta_done   = done_q;
    assign restart_err = err_q;

endmodule

// File: tb/tb_pack_metadata_mc.sv
// Directed bench for pack_metadata_mc: default instance plus a fill-pattern instance
// sharing the same stimulus.
module tb_pack_metadata_mc;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         init;
    logic [31:0]  data_in;
    logic         strobe_in;
    logic [464:0] meta_data;
    logic [31:0]  data_out, fdata_out;
    logic         strobe_out, meta_busy, meta_done, restart_err;
    logic         fstrobe_out, fmeta_busy, fmeta_done, frestart_err;

    int checks   = 0;
    int failures = 0;

    pack_metadata_mc dut (
        .clock(clk), .reset(reset), .enable(enable), .init(init),
        .data_in(data_in), .strobe_in(strobe_in), .meta_data(meta_data),
        .data_out(data_out), .strobe_out(strobe_out), .meta_busy(meta_busy),
        .meta_done(meta_done), .restart_err(restart_err)
    );

    pack_metadata_mc #(.fill_value(4'hA)) dut_fill (
        .clock(clk), .reset(reset), .enable(enable), .init(init),
        .data_in(data_in), .strobe_in(strobe_in), .meta_data(meta_data),
        .data_out(fdata_out), .strobe_out(fstrobe_out), .meta_busy(fmeta_busy),
        .meta_done(fmeta_done), .restart_err(frestart_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [3:0] h0, input logic [3:0] h1);
        return {h1, 12'hABC, h0, 12'hABC};
    endfunction

    task automatic do_init(input logic [464:0] md);
        meta_data = md;
        init      = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
    endtask

    task automatic do_strobe(input logic en);
        enable    = en;
        strobe_in = 1'b1;
        @(posedge clk);
        #1;
        strobe_in = 1'b0;
        enable    = 1'b1;
    endtask

    initial begin
        logic [31:0] prev;
        reset     = 1'b1;
        enable    = 1'b1;
        init      = 1'b0;
        strobe_in = 1'b0;
        data_in   = {16'hFABC, 16'hFABC};
        meta_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", data_out, 32'h0);
        check("rst_strobe", {31'b0, strobe_out}, 32'h0);
        check("rst_busy", {31'b0, meta_busy}, 32'h0);
        check("rst_done", {31'b0, meta_done}, 32'h0);
        check("rst_err", {31'b0, restart_err}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_strobe(1'b1);
        check("idle_fill", fdata_out, word(4'hA, 4'hA));

        // Single set bit: only slot 0 ch0 carries metadata.
        do_init(465'h1);
        check("t1_busy_rise", {31'b0, meta_busy}, 32'h1);
        check("t1_no_err", {31'b0, restart_err}, 32'h0);
        for (int i = 0; i < 60; i++) begin
            do_strobe(1'b1);
            check($sformatf("t1_data%0d", i), data_out, (i == 0) ? word(4'h1, 4'h0) : word(4'h0, 4'h0));
            check($sformatf("t1_stb%0d", i), {31'b0, strobe_out}, 32'h1);
            check($sformatf("t1_done%0d", i), {31'b0, meta_done}, {31'b0, (i == 58)});
            check($sformatf("t1_busy%0d", i), {31'b0, meta_busy}, {31'b0, (i < 58)});
        end
        check("t1_idle_fill", fdata_out, word(4'hA, 4'hA));

        // All ones: final slot truncated to bit 464.
        do_init({465{1'b1}});
        for (int i = 0; i < 59; i++) begin
            do_strobe(1'b1);
            check($sformatf("t2_data%0d", i), data_out, (i < 58) ? word(4'hF, 4'hF) : word(4'h1, 4'h0));
            check($sformatf("t2_done%0d", i), {31'b0, meta_done}, {31'b0, (i == 58)});
        end
        check("t2_busy_fall", {31'b0, meta_busy}, 32'h0);

        // Pacing with enable low between strobes.
        do_init(465'h87654321);
        do_strobe(1'b1);
        check("t3_slot0", data_out, word(4'h1, 4'h2));
        do_strobe(1'b0);
        check("t3_gap_stb", {31'b0, strobe_out}, 32'h0);
        check("t3_gap_hold", data_out, word(4'h1, 4'h2));
        do_strobe(1'b1);
        check("t3_slot1", data_out, word(4'h3, 4'h4));
        do_strobe(1'b0);
        check("t3_gap2_stb", {31'b0, strobe_out}, 32'h0);
        do_strobe(1'b1);
        check("t3_slot2", data_out, word(4'h5, 4'h6));
        for (int i = 0; i < 56; i++) begin
            do_strobe(1'b1);
            check($sformatf("t3_done%0d", i), {31'b0, meta_done}, {31'b0, (i == 55)});
        end
        check("t3_busy_fall", {31'b0, meta_busy}, 32'h0);

        // Restart after 10 slots.
        do_init(465'h9);
        for (int i = 0; i < 10; i++) begin
            do_strobe(1'b1);
            if (i == 0) check("t4_old_slot0", data_out, word(4'h9, 4'h0));
            check($sformatf("t4_old_done%0d", i), {31'b0, meta_done}, 32'h0);
        end
        do_init(465'h5);
        check("t4_err", {31'b0, restart_err}, 32'h1);
        check("t4_busy", {31'b0, meta_busy}, 32'h1);
        for (int j = 0; j < 59; j++) begin
            do_strobe(1'b1);
            if (j == 0) begin
                check("t4_new_slot0", data_out, word(4'h5, 4'h0));
                check("t4_err_pulse", {31'b0, restart_err}, 32'h0);
            end
            check($sformatf("t4_done%0d", j), {31'b0, meta_done}, {31'b0, (j == 58)});
        end

        // init and strobe in the same cycle.
        meta_data = 465'h3;
        init      = 1'b1;
        do_strobe(1'b1);
        init = 1'b0;
        check("t5_same_cycle", data_out, word(4'h3, 4'h0));
        check("t5_busy", {31'b0, meta_busy}, 32'h1);
        check("t5_done0", {31'b0, meta_done}, 32'h0);
        check("t5_no_err", {31'b0, restart_err}, 32'h0);
        for (int j = 1; j < 59; j++) begin
            do_strobe(1'b1);
            check($sformatf("t5_done%0d", j), {31'b0, meta_done}, {31'b0, (j == 58)});
        end

        // Reset mid-pack with a strobe present.
        do_init({465{1'b1}});
        for (int i = 0; i < 20; i++) do_strobe(1'b1);
        reset     = 1'b1;
        strobe_in = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        strobe_in = 1'b0;
        check("t6_data", data_out, 32'h0);
        check("t6_strobe", {31'b0, strobe_out}, 32'h0);
        check("t6_busy", {31'b0, meta_busy}, 32'h0);
        check("t6_done", {31'b0, meta_done}, 32'h0);
        check("t6_err", {31'b0, restart_err}, 32'h0);
        do_strobe(1'b1);
        check("t6_after_data", data_out, word(4'h0, 4'h0));
        check("t6_after_fill", fdata_out, word(4'hA, 4'hA));
        prev = '0;
        for (int i = 0; i < 40; i++) begin
            do_strobe(1'b1);
            prev = prev | {31'b0, meta_done};
        end
        check("t6_no_done", prev, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
